conv_acc_ctrl: RTL and testbench
================================

Name: conv_acc_ctrl

Overview:
Sequencer for the channel-batch partial-sum accumulator in the conv kernel path. For one output tile it steps the accumulator through the input-channel batches, 8 channels per batch, and drives the accumulator's batch_type code and valid gating. It throttles the upstream pixel stream with a ready signal and flags the final accumulated results. It sits between the PE-array output stream and the accumulator, and is configured per tile by the layer scheduler.

Parameters:
PIX_W, 13, width of per-batch pixel count; the count must not exceed the accumulator FIFO depth of 4096.
BAT_W, 8, width of batch count.
GAP_CYC, 4, idle cycles forced between batches so the accumulator's last registered FIFO write lands before the next batch reads.

Ports:
sclk  in  1  clock
s_rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle start pulse; sampled only in IDLE
cfg_batch_num  in  BAT_W  number of channel batches, legal range ≥2
cfg_pix_num  in  PIX_W  pixels per batch, legal range 1..4096
up_vld  in  1  upstream partial-sum valid
up_rdy  out  1  ready to upstream
acc_vld  out  1  to accumulator data_in_vld; equals up_vld & up_rdy (combinational)
acc_batch_type  out  2  to accumulator: 0 = first batch, 1 = middle batch, 2 = last batch
res_vld  out  1  accumulator data_out is a final result this cycle
busy  out  1  tile in progress
done  out  1  one-cycle pulse after the last result
cfg_err  out  1  one-cycle pulse on an illegal config

Behaviour:
- Reset: FSM=IDLE; counters=0; up_rdy=0; res_vld=0; busy=0; done=0; cfg_err=0; acc_batch_type=0.
- States: IDLE, RUN, GAP, DRAIN.
- IDLE:
  - cfg_start with cfg_batch_num<2, cfg_pix_num=0 or cfg_pix_num>4096 -> cfg_err pulses the next cycle; stay IDLE.
  - cfg_start with a legal config -> latch the config; go to RUN; batch_cnt=0; pix_cnt=0; busy=1 the next cycle.
- acc_batch_type is registered and decoded from batch_cnt: 0 when batch_cnt=0, 2 when batch_cnt=num-1, otherwise 1. It holds its value through GAP.
- RUN:
  - up_rdy=1. Each handshake (up_vld & up_rdy) increments pix_cnt.
  - On the handshake with pix_cnt=num_pix-1: clear pix_cnt.
  - If this was the last batch, go to DRAIN; otherwise increment batch_cnt and go to GAP.
- GAP:
  - up_rdy=0; gap_cnt counts GAP_CYC cycles, then go to RUN.
  - acc_batch_type updates on GAP entry, so it is stable before the first handshake of the new batch.
- DRAIN: up_rdy=0. One cycle later (after the last res_vld) pulse done, clear busy, go to IDLE.
- res_vld: registered copy of (acc_vld & type==2). It is asserted 1 cycle after the handshake, aligned with the accumulator's registered data_out.
- Bubbles: up_vld low inside RUN stalls the counters only; there is no timeout.
- cfg_start while busy is ignored (no cfg_err).
- Count check: exactly batch_num*pix_num handshakes per tile, and exactly pix_num res_vld pulses.
- Reset mid-tile: returns to IDLE immediately. The accumulator FIFO is reset by the same s_rst_n, so no residue remains.
- Width rules:
  - Counter compares use the latched config.
  - pix_cnt is PIX_W wide; no wrap occurs because the max value is 4095.

Decomposition:
- Shared package conv_acc_pkg holds:
  - batch_type codes: BT_FIRST=0, BT_MID=1, BT_LAST=2;
  - the FSM state encoding;
  - ACC_FIFO_DEPTH=4096.
- Optional sub-module conv_acc_cnt: a generic terminal-count counter with enable and clear, instantiated for pix, batch and gap. Everything else stays flat.

Test Plan:
- batch_num=3, pix_num=4, up_vld held high -> acc_batch_type sequence is 0×4, 1×4, 2×4, with up_rdy low for 4 cycles between batches. Exactly 4 res_vld pulses, the first 1 cycle after the 9th handshake. done pulses 1 cycle after the last res_vld.
- batch_num=2, pix_num=4096 with a golden accumulator model -> each data_out equals the sum of the batch-0 and batch-1 inputs per pixel. No FIFO overflow; total of 8192 handshakes.
- cfg_batch_num=1 and, separately, cfg_pix_num=0 -> cfg_err pulses once each; busy stays 0 and up_rdy stays 0.
- Random up_vld bubbles (50%), batch_num=4, pix_num=7 -> 28 handshakes total, 7 res_vld pulses, and acc_batch_type never changes while acc_vld=1 at a batch boundary.
- s_rst_n asserted in the middle of batch 1, then a new tile (batch 2, pix 3) -> all outputs return to reset values asynchronously. The new tile produces 3 correct results, unaffected by the earlier data.
- cfg_start pulsed during RUN -> ignored; tile counts unchanged; no cfg_err.

Source files
------------

// File: rtl/conv_acc_pkg.sv
package conv_acc_pkg;

  localparam int unsigned ACC_FIFO_DEPTH = 4096;

  typedef enum logic [1:0] {
    BT_FIRST = 2'd0,
    BT_MID   = 2'd1,
    BT_LAST  = 2'd2
  } batch_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/conv_acc_cnt.sv
module conv_acc_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         sclk,
  input  logic         s_rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n)  cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/conv_acc_ctrl.sv
module conv_acc_ctrl
  import conv_acc_pkg::*;
#(
  parameter int unsigned PIX_W   = 13,
  parameter int unsigned BAT_W   = 8,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic             cfg_start,
  input  logic [BAT_W-1:0] cfg_batch_num,
  input  logic [PIX_W-1:0] cfg_pix_num,
  input  logic             up_vld,
  output logic             up_rdy,
  output logic             acc_vld,
  output logic [1:0]       acc_batch_type,
  output logic             res_vld,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_t           state, state_nxt;
  batch_type_t      bt_q;
  logic [BAT_W-1:0] bat_num_q, bat_cnt;
  logic [PIX_W-1:0] pix_num_q, pix_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             cfg_ok, start_ok, hs, pix_tc, bat_tc, gap_tc, batch_end;

  assign cfg_ok    = (cfg_batch_num >= BAT_W'(2)) && (cfg_pix_num != '0) &&
                     (32'(cfg_pix_num) <= ACC_FIFO_DEPTH);
  assign start_ok  = (state == IDLE) && cfg_start;
  assign hs        = up_vld && up_rdy;
  assign acc_vld   = hs;
  assign pix_tc    = (pix_cnt == pix_num_q - PIX_W'(1));
  assign bat_tc    = (bat_cnt == bat_num_q - BAT_W'(1));
  assign gap_tc    = (state == GAP) && (gap_cnt == GAP_W'(GAP_CYC - 1));
  assign batch_end = hs && pix_tc;
  assign busy      = (state != IDLE);
  assign acc_batch_type = bt_q;

  conv_acc_cnt #(.W(PIX_W)) u_pix_cnt (
    .sclk(sclk), .s_rst_n(s_rst_n),
    .clr(start_ok || batch_end), .en(hs), .cnt(pix_cnt)
  );

  conv_acc_cnt #(.W(BAT_W)) u_bat_cnt (
    .sclk(sclk), .s_rst_n(s_rst_n),
    .clr(start_ok), .en(batch_end && !bat_tc), .cnt(bat_cnt)
  );

  conv_acc_cnt #(.W(GAP_W)) u_gap_cnt (
    .sclk(sclk), .s_rst_n(s_rst_n),
    .clr(start_ok || gap_tc), .en(state == GAP), .cnt(gap_cnt)
  );

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    up_rdy    = 1'b0;
    case (state)
      IDLE:  if (cfg_start && cfg_ok) state_nxt = RUN;
      RUN: begin
        up_rdy = 1'b1;
        if (batch_end) state_nxt = bat_tc ? DRAIN : GAP;
      end
      GAP:   if (gap_tc) state_nxt = RUN;
      DRAIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // type for the next batch is decoded at GAP entry from bat_cnt+1, since bat_cnt itself updates on the same edge
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      bat_num_q <= '0;
      pix_num_q <= '0;
      bt_q      <= BT_FIRST;
      res_vld   <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      res_vld <= hs && (bt_q == BT_LAST);
      done    <= (state == DRAIN);
      cfg_err <= start_ok && !cfg_ok;
      if (start_ok && cfg_ok) begin
        bat_num_q <= cfg_batch_num;
        pix_num_q <= cfg_pix_num;
        bt_q      <= BT_FIRST;
      end else if (batch_end && !bat_tc) begin
        bt_q <= (bat_cnt + BAT_W'(1) == bat_num_q - BAT_W'(1)) ? BT_LAST : BT_MID;
      end
    end
  end

endmodule

// File: tb/tb_conv_acc_ctrl.sv
module tb_conv_acc_ctrl;

  logic       sclk;
  logic       s_rst_n;
  logic       cfg_start;
  logic [7:0] cfg_batch_num;
  logic [12:0] cfg_pix_num;
  logic       up_vld;
  logic       up_rdy, acc_vld, res_vld, busy, done, cfg_err;
  logic [1:0] acc_batch_type;

  conv_acc_ctrl #(.PIX_W(13), .BAT_W(8), .GAP_CYC(4)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .cfg_start(cfg_start),
    .cfg_batch_num(cfg_batch_num), .cfg_pix_num(cfg_pix_num),
    .up_vld(up_vld), .up_rdy(up_rdy), .acc_vld(acc_vld),
    .acc_batch_type(acc_batch_type), .res_vld(res_vld), .busy(busy),
    .done(done), .cfg_err(cfg_err)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int cur_batch = 0;
  int cur_pix   = 0;

  function automatic int data_of(input int b, input int p);
    return b * 1000 + p * 7 + 3;
  endfunction

  function automatic int exp_sum(input int p);
    int s = 0;
    for (int i = 0; i < cur_batch; i++) s += data_of(i, p);
    return s;
  endfunction

  int hs_cnt = 0, res_cnt = 0, err_cnt = 0, done_cnt = 0, busy_cyc = 0, rdy_cyc = 0;
  int type_err = 0, res_err = 0, sum_err = 0, vld_err = 0;
  int tile_hs = 0;
  int mem [4096];
  bit pend_last = 0;
  int pend_sum = 0, pend_pix = 0;
  int mb, mp, met, md;

  // monitor + golden accumulator, sampled on the falling edge
  always @(negedge sclk) begin
    if (!s_rst_n) begin
      tile_hs   = 0;
      pend_last = 0;
    end else begin
      if (res_vld !== pend_last) res_err++;
      if (res_vld) begin
        res_cnt++;
        if (pend_last && pend_sum != exp_sum(pend_pix)) sum_err++;
      end
      pend_last = 0;
      if (acc_vld !== (up_vld & up_rdy)) vld_err++;
      if (acc_vld && cur_pix > 0) begin
        mb  = tile_hs / cur_pix;
        mp  = tile_hs % cur_pix;
        met = (mb == 0) ? 0 : ((mb == cur_batch - 1) ? 2 : 1);
        if (int'(acc_batch_type) != met) type_err++;
        md = data_of(mb, mp);
        case (acc_batch_type)
          2'd0: mem[mp] = md;
          2'd1: mem[mp] = mem[mp] + md;
          default: begin
            pend_sum = mem[mp] + md;
            pend_pix = mp;
          end
        endcase
        pend_last = (met == 2);
        hs_cnt++;
        tile_hs++;
      end
      if (done)    done_cnt++;
      if (cfg_err) err_cnt++;
      if (busy)    busy_cyc++;
      if (up_rdy)  rdy_cyc++;
      if (cfg_start && !busy) tile_hs = 0;
    end
  end

  task automatic start_tile(input int b, input int p);
    @(posedge sclk); #1;
    cfg_start     = 1'b1;
    cfg_batch_num = 8'(b);
    cfg_pix_num   = 13'(p);
    cur_batch     = b;
    cur_pix       = p;
    @(posedge sclk); #1;
    cfg_start     = 1'b0;
    cfg_batch_num = 8'd1;
    cfg_pix_num   = 13'd0;
  endtask

  typedef struct {
    int    b;
    int    p;
    bit    bubble;
    bit    mid;
    int    hs;
    int    res;
    int    err;
    int    dn;
    int    bsy;
    string name;
  } vec_t;

  task automatic run_tile(input vec_t v);
    int hs0 = hs_cnt, res0 = res_cnt, err0 = err_cnt, dn0 = done_cnt;
    int bz0 = busy_cyc, rd0 = rdy_cyc, te0 = type_err, re0 = res_err;
    int se0 = sum_err, ve0 = vld_err;
    int cyc = 0;
    start_tile(v.b, v.p);
    while (cyc < 20000) begin
      @(posedge sclk); #1;
      up_vld    = v.bubble ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_start = v.mid && (cyc == 6);
      cyc++;
      if (done_cnt != dn0) break;
      if (v.dn == 0 && cyc >= 12) break;
    end
    repeat (3) begin
      @(posedge sclk); #1;
      cfg_start = 1'b0;
      up_vld    = 1'b1;
    end
    check({v.name, "_handshakes"}, hs_cnt - hs0, v.hs);
    check({v.name, "_res_vld"},    res_cnt - res0, v.res);
    check({v.name, "_cfg_err"},    err_cnt - err0, v.err);
    check({v.name, "_done"},       done_cnt - dn0, v.dn);
    check({v.name, "_type_errs"},  type_err - te0, 0);
    check({v.name, "_res_timing"}, res_err - re0, 0);
    check({v.name, "_acc_sum"},    sum_err - se0, 0);
    check({v.name, "_acc_vld"},    vld_err - ve0, 0);
    if (v.bsy >= 0) check({v.name, "_busy_cycles"}, busy_cyc - bz0, v.bsy);
    if (v.hs == 0)  check({v.name, "_rdy_cycles"},  rdy_cyc - rd0, 0);
  endtask

  vec_t tbl[9];

  initial begin
    logic [21:0] got_rdy, got_res, got_done, got_busy;
    logic [21:0] exp_rdy, exp_res, exp_done, exp_busy;
    int exp_t[22];
    int t_bad;
    int w;

    tbl[0] = '{3, 4,    1'b0, 1'b0, 12,   4,    0, 1, 21,   "b3p4"};
    tbl[1] = '{2, 4096, 1'b0, 1'b0, 8192, 4096, 0, 1, 8197, "b2p4096"};
    tbl[2] = '{1, 4,    1'b0, 1'b0, 0,    0,    1, 0, 0,    "bad_batch1"};
    tbl[3] = '{3, 0,    1'b0, 1'b0, 0,    0,    1, 0, 0,    "bad_pix0"};
    tbl[4] = '{2, 4097, 1'b0, 1'b0, 0,    0,    1, 0, 0,    "bad_pix4097"};
    tbl[5] = '{4, 7,    1'b1, 1'b0, 28,   7,    0, 1, -1,   "bubble_b4p7"};
    tbl[6] = '{3, 5,    1'b0, 1'b1, 15,   5,    0, 1, 24,   "start_in_run"};
    tbl[7] = '{2, 1,    1'b0, 1'b0, 2,    1,    0, 1, 7,    "b2p1"};
    tbl[8] = '{0, 4,    1'b0, 1'b0, 0,    0,    1, 0, 0,    "bad_batch0"};

    s_rst_n       = 1'b0;
    cfg_start     = 1'b0;
    cfg_batch_num = '0;
    cfg_pix_num   = '0;
    up_vld        = 1'b0;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    check("reset_outputs", int'({up_rdy, acc_vld, res_vld, busy, done, cfg_err, acc_batch_type}), 0);
    @(posedge sclk); #1;
    s_rst_n = 1'b1;
    up_vld  = 1'b1;

    // cycle-exact trace of a 3x4 tile, k=0 is the first cycle in RUN
    exp_rdy  = 22'b00_1111_0000_1111_0000_1111;
    exp_res  = 22'b01_1110_0000_0000_0000_0000;
    exp_done = 22'b10_0000_0000_0000_0000_0000;
    exp_busy = 22'b01_1111_1111_1111_1111_1111;
    exp_t    = '{0,0,0,0,1,1,1,1,1,1,1,1,2,2,2,2,2,2,2,2,2,2};
    t_bad    = 0;
    start_tile(3, 4);
    for (int k = 0; k < 22; k++) begin
      @(negedge sclk);
      got_rdy[k]  = up_rdy;
      got_res[k]  = res_vld;
      got_done[k] = done;
      got_busy[k] = busy;
      if (int'(acc_batch_type) != exp_t[k]) t_bad++;
    end
    check("trace_up_rdy",  int'(got_rdy),  int'(exp_rdy));
    check("trace_res_vld", int'(got_res),  int'(exp_res));
    check("trace_done",    int'(got_done), int'(exp_done));
    check("trace_busy",    int'(got_busy), int'(exp_busy));
    check("trace_batch_type_errs", t_bad, 0);
    repeat (2) @(posedge sclk);

    for (int i = 0; i < 9; i++) run_tile(tbl[i]);

    // asynchronous reset in the middle of batch 1, then a fresh tile
    start_tile(3, 5);
    w = 0;
    while (w < 100 && tile_hs < 7) begin
      @(posedge sclk); #1;
      w++;
    end
    check("mid_tile_reached", int'(acc_batch_type), 1);
    #2;
    s_rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'({up_rdy, acc_vld, res_vld, busy, done, cfg_err, acc_batch_type}), 0);
    @(negedge sclk);
    @(posedge sclk); #1;
    s_rst_n = 1'b1;
    run_tile('{2, 3, 1'b0, 1'b0, 6, 3, 0, 1, 11, "after_reset"});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
